// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout
// Revision 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int OP_WIDTH    = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [OP_WIDTH-1:0]  op,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 i_or_d,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src,
  output logic                 branch,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic [1:0]           alu_op,
  output logic                 instr_done,
  output logic                 illegal_op,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM_RD = 3'd4,
    S_MEM_WR = 3'd5,
    S_WB_ALU = 3'd6,
    S_WB_MEM = 3'd7
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic   w_op_illegal;
  logic   w_timeout;
  logic   w_mem_state;
  state_t w_after_retire;

  // Only opcodes 0..3 exist; any set bit above bit 1 makes the opcode illegal.
  generate
    if (OP_WIDTH > 2) begin : g_op_wide
      assign w_op_illegal = |op[OP_WIDTH-1:2];
    end else begin : g_op_narrow
      assign w_op_illegal = 1'b0;
    end
  endgenerate

  // This cycle is the MEM_TIMEOUT-th consecutive not-ready cycle.
  assign w_timeout      = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_LAST);
  assign w_mem_state    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign w_after_retire = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_error  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (w_timeout) begin
          bus_error = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DECODE: begin
        op_d = op[1:0];
        if (w_op_illegal) begin
          illegal_op = 1'b1;
          state_d    = w_after_retire;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          2'd0: begin
            alu_op  = 2'b10;
            state_d = S_WB_ALU;
          end
          2'd1: begin
            alu_src = 1'b1;
            state_d = S_MEM_RD;
          end
          2'd2: begin
            alu_src = 1'b1;
            state_d = S_MEM_WR;
          end
          2'd3: begin
            branch     = 1'b1;
            alu_op     = 2'b01;
            instr_done = 1'b1;
            state_d    = w_after_retire;
          end
        endcase
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (w_timeout) begin
          bus_error = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = w_after_retire;
        end else if (w_timeout) begin
          bus_error = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WB_ALU: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = w_after_retire;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = w_after_retire;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Staying in a memory state implies a not-ready cycle; any state change clears the count.
  always_comb begin
    wait_d = '0;
    if (w_mem_state && (state_d == state_q) && (MEM_TIMEOUT != 0)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (instr_done) count_d = count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control : vector table, corner sequences and random vs model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  localparam int OP_W  = 3;
  localparam int CNT_W = 4;
  localparam int TO    = 4;

  localparam logic [14:0] B_PCW     = 15'h4000;
  localparam logic [14:0] B_IRW     = 15'h2000;
  localparam logic [14:0] B_IOD     = 15'h1000;
  localparam logic [14:0] B_RDST    = 15'h0800;
  localparam logic [14:0] B_RW      = 15'h0400;
  localparam logic [14:0] B_ASRC    = 15'h0200;
  localparam logic [14:0] B_BR      = 15'h0100;
  localparam logic [14:0] B_MRD     = 15'h0080;
  localparam logic [14:0] B_MWR     = 15'h0040;
  localparam logic [14:0] B_M2R     = 15'h0020;
  localparam logic [14:0] B_ALU_FN  = 15'h0010;
  localparam logic [14:0] B_ALU_SUB = 15'h0008;
  localparam logic [14:0] B_DONE    = 15'h0004;
  localparam logic [14:0] B_ILL     = 15'h0002;
  localparam logic [14:0] B_BERR    = 15'h0001;

  localparam int P_F = 0, P_D = 1, P_E = 2, P_MR = 3, P_MW = 4, P_WA = 5, P_WM = 6;

  logic clk = 1'b0;
  logic rst, run, mem_ready;
  logic [OP_W-1:0] op;
  logic pc_write, ir_write, i_or_d, reg_dst, reg_write, alu_src, branch;
  logic mem_read, mem_write, mem_to_reg, instr_done, illegal_op, bus_error;
  logic [1:0] alu_op;
  logic [CNT_W-1:0] instr_count;
  logic [14:0] dut_sig;

  multicycle_control #(.OP_WIDTH(OP_W), .CNT_WIDTH(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src(alu_src), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .bus_error(bus_error),
    .instr_count(instr_count)
  );

  assign dut_sig = {pc_write, ir_write, i_or_d, reg_dst, reg_write, alu_src, branch,
                    mem_read, mem_write, mem_to_reg, alu_op, instr_done, illegal_op, bus_error};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each opcode is a program of phases; -1 ends the instruction.
  int prog [4][5];
  int m_pos;
  int m_op;
  int m_wait;
  int m_cnt;

  logic [14:0] got_sig, exp_sig;
  int          got_cnt, exp_cnt;

  function automatic bit tmo(input logic rdy);
    return !rdy && (m_wait + 1 == TO);
  endfunction

  function automatic logic [14:0] model_out(input int opin, input logic rdy);
    logic [14:0] e;
    e = 15'h0;
    if (m_pos >= 0) begin
      case (prog[m_op][m_pos])
        P_F:  e = B_MRD | (rdy ? (B_PCW | B_IRW) : 15'h0) | (tmo(rdy) ? B_BERR : 15'h0);
        P_D:  e = (opin >= 4) ? B_ILL : 15'h0;
        P_E:  e = (m_op == 0) ? B_ALU_FN :
                  (m_op == 3) ? (B_BR | B_ALU_SUB | B_DONE) : B_ASRC;
        P_MR: e = B_MRD | B_IOD | (tmo(rdy) ? B_BERR : 15'h0);
        P_MW: e = B_MWR | B_IOD | (rdy ? B_DONE : 15'h0) | (tmo(rdy) ? B_BERR : 15'h0);
        P_WA: e = B_RDST | B_RW | B_DONE;
        P_WM: e = B_RW | B_M2R | B_DONE;
        default: e = 15'h0;
      endcase
    end
    return e;
  endfunction

  task automatic model_step(input logic r, input logic rn, input int opin, input logic rdy);
    logic [14:0] e;
    int ph;
    if (r) begin
      m_pos = -1; m_op = 0; m_wait = 0; m_cnt = 0;
      return;
    end
    e = model_out(opin, rdy);
    if ((e & B_DONE) != 15'h0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (m_pos < 0) begin
      if (rn) m_pos = 0;
      m_wait = 0;
      return;
    end
    ph = prog[m_op][m_pos];
    if ((ph == P_F || ph == P_MR || ph == P_MW) && !rdy) begin
      if (tmo(rdy)) begin
        m_pos = -1; m_wait = 0;
      end else begin
        m_wait++;
      end
      return;
    end
    m_wait = 0;
    if (ph == P_D) begin
      m_op = opin % 4;
      if (opin >= 4) begin
        m_pos = rn ? 0 : -1;
        return;
      end
    end
    if (m_pos + 1 < 5 && prog[m_op][m_pos + 1] >= 0) m_pos++;
    else m_pos = rn ? 0 : -1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One clock: drive inputs, sample at negedge against the model, then advance the model.
  task automatic apply(input logic r, input logic rn, input int opin, input logic rdy, input bit chk);
    rst = r; run = rn; op = OP_W'(opin); mem_ready = rdy;
    @(negedge clk);
    got_sig = dut_sig;
    got_cnt = int'(instr_count);
    exp_sig = model_out(opin, rdy);
    exp_cnt = m_cnt;
    if (chk) begin
      check("model_sig", 32'(got_sig), 32'(exp_sig));
      check("model_cnt", got_cnt, exp_cnt);
    end
    @(posedge clk);
    #1;
    model_step(r, rn, opin, rdy);
  endtask

  typedef struct {
    logic        r;
    logic        rn;
    int          opin;
    logic        rdy;
    logic [14:0] sig;
    int          cnt;
  } vec_t;

  vec_t tv [16];
  int   thr;

  initial begin
    prog[0] = '{P_F, P_D, P_E, P_WA, -1};
    prog[1] = '{P_F, P_D, P_E, P_MR, P_WM};
    prog[2] = '{P_F, P_D, P_E, P_MW, -1};
    prog[3] = '{P_F, P_D, P_E, -1, -1};
    m_pos = -1; m_op = 0; m_wait = 0; m_cnt = 0;

    // ADD then LOAD with three not-ready cycles in MEM_RD, then run dropped
    tv[0]  = '{1'b1, 1'b0, 0, 1'b0, 15'h0, 0};
    tv[1]  = '{1'b0, 1'b1, 0, 1'b1, 15'h0, 0};
    tv[2]  = '{1'b0, 1'b1, 0, 1'b1, B_MRD | B_PCW | B_IRW, 0};
    tv[3]  = '{1'b0, 1'b1, 0, 1'b1, 15'h0, 0};
    tv[4]  = '{1'b0, 1'b1, 0, 1'b1, B_ALU_FN, 0};
    tv[5]  = '{1'b0, 1'b1, 0, 1'b1, B_RDST | B_RW | B_DONE, 0};
    tv[6]  = '{1'b0, 1'b1, 1, 1'b1, B_MRD | B_PCW | B_IRW, 1};
    tv[7]  = '{1'b0, 1'b1, 1, 1'b1, 15'h0, 1};
    tv[8]  = '{1'b0, 1'b1, 1, 1'b1, B_ASRC, 1};
    tv[9]  = '{1'b0, 1'b1, 1, 1'b0, B_MRD | B_IOD, 1};
    tv[10] = '{1'b0, 1'b1, 1, 1'b0, B_MRD | B_IOD, 1};
    tv[11] = '{1'b0, 1'b1, 1, 1'b0, B_MRD | B_IOD, 1};
    tv[12] = '{1'b0, 1'b1, 1, 1'b1, B_MRD | B_IOD, 1};
    tv[13] = '{1'b0, 1'b0, 1, 1'b1, B_RW | B_M2R | B_DONE, 1};
    tv[14] = '{1'b0, 1'b0, 0, 1'b1, 15'h0, 2};
    tv[15] = '{1'b0, 1'b0, 0, 1'b1, 15'h0, 2};

    apply(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      apply(tv[i].r, tv[i].rn, tv[i].opin, tv[i].rdy, 1'b1);
      check($sformatf("vec%0d_sig", i), 32'(got_sig), 32'(tv[i].sig));
      check($sformatf("vec%0d_cnt", i), got_cnt, tv[i].cnt);
    end

    // Back-to-back BEQs: one retirement every third cycle, count wraps 15 -> 0
    apply(1'b0, 1'b1, 3, 1'b1, 1'b1);
    for (int k = 0; k < 14; k++) begin
      apply(1'b0, 1'b1, 3, 1'b1, 1'b1);
      check("wrap_cnt", got_cnt, (2 + k) % 16);
      apply(1'b0, 1'b1, 3, 1'b1, 1'b1);
      apply(1'b0, 1'b1, 3, 1'b1, 1'b1);
      check("beq_exec", 32'(got_sig), 32'(B_BR | B_ALU_SUB | B_DONE));
    end
    apply(1'b0, 1'b1, 3, 1'b1, 1'b1);
    check("wrap_zero", got_cnt, 0);

    // Illegal opcode 5 in DECODE
    apply(1'b0, 1'b1, 5, 1'b1, 1'b1);
    check("illegal_pulse", 32'(got_sig), 32'(B_ILL));
    apply(1'b0, 1'b1, 2, 1'b1, 1'b1);
    check("illegal_refetch", 32'(got_sig), 32'(B_MRD | B_PCW | B_IRW));
    check("illegal_nocount", got_cnt, 0);

    // STORE that never gets mem_ready: bus_error on the fourth wait cycle
    apply(1'b0, 1'b1, 2, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 2, 1'b1, 1'b1);
    for (int w = 0; w < 4; w++) begin
      apply(1'b0, 1'b1, 2, 1'b0, 1'b1);
      check($sformatf("timeout_w%0d", w), 32'(got_sig),
            32'(B_MWR | B_IOD | ((w == 3) ? B_BERR : 15'h0)));
    end
    apply(1'b0, 1'b1, 2, 1'b1, 1'b1);
    check("timeout_idle", 32'(got_sig), 32'(15'h0));
    check("timeout_cnt", got_cnt, 0);

    // STORE whose ready arrives on the fourth cycle: completion beats timeout
    apply(1'b0, 1'b1, 2, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 2, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 2, 1'b1, 1'b1);
    for (int w = 0; w < 3; w++) apply(1'b0, 1'b1, 2, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 2, 1'b1, 1'b1);
    check("late_ready", 32'(got_sig), 32'(B_MWR | B_IOD | B_DONE));
    apply(1'b0, 1'b1, 0, 1'b1, 1'b1);
    check("late_ready_cnt", got_cnt, 1);

    // ADD with run dropped in EXEC: completes, then IDLE
    apply(1'b0, 1'b1, 0, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 0, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 0, 1'b1, 1'b1);
    check("rundrop_wb", 32'(got_sig), 32'(B_RDST | B_RW | B_DONE));
    apply(1'b0, 1'b0, 0, 1'b1, 1'b1);
    check("rundrop_idle", 32'(got_sig), 32'(15'h0));
    check("rundrop_cnt", got_cnt, 2);

    // Reset asserted while waiting in MEM_RD
    apply(1'b0, 1'b1, 1, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1, 1'b0, 1'b1);
    check("memrd_wait", 32'(got_sig), 32'(B_MRD | B_IOD));
    apply(1'b1, 1'b1, 1, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1, 1'b1, 1'b1);
    check("rst_sig", 32'(got_sig), 32'(15'h0));
    check("rst_cnt", got_cnt, 0);

    // Randomised traffic against the model, with bursts of varying memory latency
    thr = 90;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       thr = 90;
          1:       thr = 50;
          default: thr = 15;
        endcase
      end
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
            int'($urandom_range(0, 7)), ($urandom_range(0, 99) < thr), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control unit for the microprocessor core. It sequences every instruction through fetch, decode, execute, memory and write-back states. It drives the datapath control strobes per state and handshakes with a shared instruction/data memory through a ready signal, with a wait timeout. It also counts retired instructions. It sits between the instruction register's opcode field and the datapath muxes, register file and memory port.

## Interface
- OP_WIDTH, 2 — opcode width; must be ≥2; opcodes ≥4 are illegal.
- CNT_WIDTH, 16 — width of the retired-instruction counter.
- MEM_TIMEOUT, 15 — maximum cycles to wait for mem_ready in one memory state; 0 disables the timeout.
- clk  in  1  — sole clock, rising edge.
- rst  in  1  — synchronous, active-high reset.
- run  in  1  — allows fetching new instructions.
- op  in  OP_WIDTH  — opcode from the instruction register; valid from DECODE onward.
- mem_ready  in  1  — memory completes the current request this cycle.
- pc_write, ir_write  out  1  — PC update and IR load strobes.
- i_or_d  out  1  — memory address select: 0 = PC, 1 = ALU result.
- reg_dst, reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg  out  1  — datapath controls.
- alu_op  out  2  — ALU operation: 00 add, 01 subtract, 10 funct-field.
- instr_done  out  1  — one-cycle pulse when an instruction retires.
- illegal_op, bus_error  out  1  — one-cycle fault pulses.
- instr_count  out  CNT_WIDTH  — count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM.
- Opcodes: 0 = ADD (R-type), 1 = LOAD, 2 = STORE, 3 = BEQ.
- IDLE
  - All strobes 0.
  - Goes to FETCH when run=1.
- FETCH
  - Drives mem_read=1, i_or_d=0.
  - When mem_ready=1: pc_write=ir_write=1 in that same cycle, then goes to DECODE.
  - Otherwise stays in FETCH.
- DECODE
  - All strobes 0.
  - Latches op into an internal opcode register.
  - Opcode ≥4: pulse illegal_op, no instr_done, no count increment; then goes to FETCH if run=1, else IDLE.
  - Otherwise goes to EXEC.
- EXEC
  - ADD: alu_op=10, then WB_ALU.
  - LOAD: alu_src=1, alu_op=00, then MEM_RD.
  - STORE: alu_src=1, alu_op=00, then MEM_WR.
  - BEQ: branch=1, alu_op=01; retires here, so instr_done=1.
- MEM_RD
  - Drives mem_read=1, i_or_d=1.
  - Goes to WB_MEM on mem_ready.
- MEM_WR
  - Drives mem_write=1, i_or_d=1.
  - Retires on mem_ready (instr_done=1).
- WB_ALU: reg_dst=1, reg_write=1; retires.
- WB_MEM: reg_write=1, mem_to_reg=1; retires.
- After retirement: goes to FETCH if run=1, else IDLE. run is sampled only at instruction boundaries; deasserting run mid-instruction does not abort it.
- Memory timeout
  - A wait counter clears on entry to each memory state and counts cycles with mem_ready=0.
  - If the counter reaches MEM_TIMEOUT while mem_ready=0: pulse bus_error, drop all strobes next cycle, go to IDLE.
  - No retirement and no count increment on timeout.
- instr_count increments by 1 on every instr_done and wraps modulo 2^CNT_WIDTH.

## Timing
- Reset: state=IDLE, instr_count=0, opcode register=0, wait counter=0.
- Reset values: every output 0.
- Reset mid-instruction abandons the instruction with no strobes in the following cycle.
- Strobes are Moore decodes of state and the opcode register.
- Exception: pc_write, ir_write, instr_done and the MEM_WR/MEM_RD exit depend combinationally on mem_ready in the current cycle.
- Latency with mem_ready tied high: ADD 4, LOAD 5, STORE 4, BEQ 3 cycles, from FETCH entry to next FETCH.
- Each cycle of mem_ready=0 in a memory state adds exactly one cycle.
- Back-to-back instructions: no bubble; FETCH follows the retiring cycle directly.
- Simultaneous events:
  - mem_ready=1 in the cycle the timeout count is reached: completion wins, no bus_error.
  - rst=1 overrides all other inputs.

## Test plan
- Reset, run=1, op=0, mem_ready=1 → state sequence FETCH, DECODE, EXEC (alu_op=10), WB_ALU (reg_dst=reg_write=1); instr_done on cycle 4; instr_count=1.
- LOAD with mem_ready low for 3 cycles in MEM_RD → mem_read=1, i_or_d=1 held for 4 cycles; WB_MEM has mem_to_reg=1; retire at cycle 8.
- Repeated BEQ, run=1 → branch=1, alu_op=01 every third cycle. Preloading instr_count to all-ones via 2^CNT_WIDTH−1 retirements (CNT_WIDTH=4: 15) → the next retirement wraps the count to 0.
- OP_WIDTH=3, op=5 → illegal_op pulse in DECODE; no reg_write, no mem_write, no instr_done; back in FETCH.
- MEM_TIMEOUT=4, STORE with mem_ready never high → bus_error after 4 wait cycles, state IDLE, mem_write=0 next cycle. Variant with mem_ready=1 on the 4th cycle → normal retire, no bus_error.
- run dropped during EXEC of an ADD → instruction completes WB_ALU, then IDLE; rst asserted during MEM_RD → all outputs 0 next cycle, instr_count=0.
